spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// Serial front end of the SPI wrapper. Deserialises MOSI frames into 10-bit words {op[1:0],byte[7:0]}
// for the single-port RAM (rx_data/rx_valid) and serialises the RAM's read byte (tx_data/tx_valid) on MISO.
// Runs on the system clock: one MOSI bit sampled and one MISO bit driven per posedge clk while SS_n is low.
// PARAMETERS
// DATA_W       8   RAM byte width; rx_data width = DATA_W+2, MISO readback length = DATA_W bits
// TX_WAIT_MAX  15  max clk edges spent waiting for tx_valid after a read-data rx_valid before abort
// PORTS
// clk       in   1         system clock, all state changes on posedge
// rst_n     in   1         asynchronous active-low reset
// SS_n      in   1         slave select, active low; high ends/aborts any frame
// MOSI      in   1         serial in, MSB first, sampled on posedge clk
// MISO      out  1         serial out, registered, MSB first; 0 when not reading back
// rx_data   out  DATA_W+2  received word {op,byte}, held until next completed frame
// rx_valid  out  1         one-cycle pulse: rx_data is a complete new word
// tx_data   in   DATA_W    read byte from RAM
// tx_valid  in   1         tx_data valid (RAM pulses it one cycle after a read-data rx_valid)
// BEHAVIOUR
// Reset (async, any state): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit_cnt=0, rd_addr_seen=0, wait_cnt=0.
// States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n sampled every edge; SS_n=1 in any non-IDLE
//   state -> IDLE next edge, partial frame discarded, no rx_valid, MISO=0, rd_addr_seen unchanged.
// IDLE: SS_n=0 -> CHK_CMD.
// CHK_CMD: sample command bit: MOSI=0 -> WRITE; MOSI=1 & !rd_addr_seen -> READ_ADD; MOSI=1 & rd_addr_seen -> READ_DATA.
// WRITE/READ_ADD/READ_DATA: shift MOSI into shreg for DATA_W+2 edges (bit_cnt 0..DATA_W+1). On the edge sampling
//   the last bit: rx_data <= {shreg[DATA_W:0],MOSI}, rx_valid=1 for exactly the following cycle.
//   Edge count from SS_n low: edge0 ->CHK_CMD, edge1 cmd bit, edges2..11 data, rx_valid high after edge11 (DATA_W=8).
// Payload forwarded unmodified; op bits not checked by this block. State selects flag handling only.
// READ_ADD: on frame completion set rd_addr_seen=1. WRITE: flag unchanged.
// After frame completion in WRITE/READ_ADD: hold state, ignore MOSI, until SS_n=1.
// READ_DATA after rx_valid: wait for tx_valid, counting wait_cnt from 0; first edge with tx_valid=1 latches
//   tx_data into oshift and MISO <= tx_data[DATA_W-1]; next DATA_W-1 edges drive remaining bits MSB->LSB;
//   edge after LSB cycle: MISO=0, rd_addr_seen=0, hold until SS_n=1. tx_valid outside wait window ignored.
// Timeout: wait_cnt reaches TX_WAIT_MAX without tx_valid -> MISO stays 0, rd_addr_seen=0, hold until SS_n=1.
// Simultaneous SS_n=1 and last data bit: SS_n wins, no rx_valid. SS_n=1 mid-readback: MISO=0 next edge,
//   rd_addr_seen NOT cleared (read data may be retried).
// New frame needs SS_n high for >=1 edge (IDLE) before going low again.
// TESTING
// Write addr: SS_n=0, MOSI 0 then 00_0000_0101 -> rx_valid 1 cycle, rx_data=10'h005, rd_addr_seen=0.
// Read addr then read data: MOSI 1,10_0000_0101 -> rx_data=10'h205, flag=1; next frame MOSI 1,11_xxxx_xxxx,
//   bench returns tx_valid with tx_data=8'hA5 -> MISO 1,0,1,0,0,1,0,1 over 8 cycles, flag=0.
// SS_n=1 after 5 data bits of write frame -> IDLE next edge, rx_valid never asserted, rx_data unchanged.
// Read data with tx_valid never asserted -> after 15 wait edges MISO=0, rd_addr_seen=0, no hang.
// rst_n=0 mid-readback (after 3 MISO bits) -> MISO=0, rx_valid=0, state IDLE, rd_addr_seen=0 immediately.
// Two back-to-back READ_ADD frames -> second frame routed to READ_DATA (flag already set).

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises {op,byte} MOSI frames into rx_data/rx_valid and replays
// the RAM read byte on MISO. One bit per posedge clk while SS_n is low.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CNT_W  = $clog2(DATA_W + 2);
  localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {PH_SHIFT, PH_WAIT, PH_SEND, PH_DONE} phase_t;

  state_t            state;
  phase_t            phase;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W:0]   shreg;
  logic [DATA_W-1:0] oshift;
  logic              rd_addr_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= PH_SHIFT;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      shreg        <= '0;
      oshift       <= '0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Deselect always wins, even over the last data bit; the read flag survives an abort
      if (state != IDLE && SS_n) begin
        state <= IDLE;
        MISO  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            MISO <= 1'b0;
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            phase    <= PH_SHIFT;
            if (!MOSI)              state <= WRITE;
            else if (!rd_addr_seen) state <= READ_ADD;
            else                    state <= READ_DATA;
          end
          default: begin
            case (phase)
              PH_SHIFT: begin
                shreg   <= {shreg[DATA_W-1:0], MOSI};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(DATA_W + 1)) begin
                  rx_data  <= {shreg, MOSI};
                  rx_valid <= 1'b1;
                  phase    <= (state == READ_DATA) ? PH_WAIT : PH_DONE;
                  if (state == READ_ADD) rd_addr_seen <= 1'b1;
                end
              end
              PH_WAIT: begin
                if (tx_valid) begin
                  MISO    <= tx_data[DATA_W-1];
                  oshift  <= tx_data << 1;
                  bit_cnt <= '0;
                  phase   <= PH_SEND;
                end else if (wait_cnt == WAIT_W'(TX_WAIT_MAX - 1)) begin
                  rd_addr_seen <= 1'b0;
                  phase        <= PH_DONE;
                end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                end
              end
              PH_SEND: begin
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  MISO         <= 1'b0;
                  rd_addr_seen <= 1'b0;
                  phase        <= PH_DONE;
                end else begin
                  MISO    <= oshift[DATA_W-1];
                  oshift  <= oshift << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Frame-level bench for spi_slave: expected outputs are derived per edge index of each frame.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .TX_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic       e_miso = 1'b0;
  logic       e_rxv = 1'b0;
  logic [9:0] e_rxd = 10'h000;
  logic [9:0] m_rxd = 10'h000;
  logic       m_flag = 1'b0;
  logic       cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the frame model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        check("miso", {31'd0, MISO}, {31'd0, e_miso});
        check("rx_valid", {31'd0, rx_valid}, {31'd0, e_rxv});
        check("rx_data", {22'd0, rx_data}, {22'd0, e_rxd});
      end
    end
  end

  // One frame: edge 0 selects, edge 1 command, edges 2..11 payload; SS_n rises at edge len.
  // tx_valid is offered on edge tx_edge; rst_edge (>=0) resets asynchronously before that edge.
  task automatic frame(input logic c, input logic [9:0] w, input int len, input int tx_edge,
                       input logic [7:0] txd, input int rst_edge,
                       output int nrxv, output logic [7:0] snap);
    int route;
    bit complete;
    int t_acc;
    logic [7:0] hist;
    route    = (c == 1'b0) ? 0 : (m_flag ? 2 : 1);
    complete = (len >= 12);
    t_acc    = (route == 2 && complete && tx_edge >= 12 && tx_edge <= 26 && tx_edge < len)
               ? tx_edge : -1;
    nrxv = 0;
    snap = 8'h00;
    hist = 8'h00;
    for (int k = 0; k <= len + 1; k++) begin
      @(negedge clk);
      if (k > 0) begin
        hist = {hist[6:0], MISO};
        if (rx_valid) nrxv++;
        if (k == 21) snap = hist;
      end
      if (k == rst_edge) begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        #1;
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        m_flag = 1'b0;
        m_rxd  = 10'h000;
        e_miso = 1'b0;
        e_rxv  = 1'b0;
        e_rxd  = 10'h000;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      SS_n     = (k >= len);
      MOSI     = (k == 1) ? c : ((k >= 2 && k <= 11) ? w[11-k] : 1'($urandom));
      tx_valid = (k == tx_edge);
      tx_data  = (k == tx_edge) ? txd : 8'($urandom);
      if (k >= len) begin
        e_miso = 1'b0;
        e_rxv  = 1'b0;
      end else begin
        e_rxv = complete && (k == 11);
        if (e_rxv) m_rxd = w;
        e_miso = (t_acc >= 0 && k >= t_acc && k <= t_acc + 7) ? txd[7-(k-t_acc)] : 1'b0;
        if (route == 1 && k == 11) m_flag = 1'b1;
        if (route == 2 && t_acc >= 0 && k == t_acc + 8) m_flag = 1'b0;
        if (route == 2 && t_acc < 0 && complete && k == 26) m_flag = 1'b0;
      end
      e_rxd = m_rxd;
    end
  endtask

  initial begin
    int n;
    logic [7:0] s;
    #1 rst_n = 1'b0;
    #1;
    check("reset_miso", {31'd0, MISO}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {22'd0, rx_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Write address 5
    frame(1'b0, 10'h005, 14, -1, 8'h00, -1, n, s);
    check("wr_pulses", n, 1);
    check("wr_rx_data", {22'd0, rx_data}, 32'h005);
    // Read address, stray tx_valid during hold is ignored
    frame(1'b1, 10'h205, 14, 13, 8'h3C, -1, n, s);
    check("ra_rx_data", {22'd0, rx_data}, 32'h205);
    check("ra_model_flag", {31'd0, m_flag}, 32'd1);
    // Read data, RAM answers one cycle after rx_valid
    frame(1'b1, 10'h3C7, 24, 13, 8'hA5, -1, n, s);
    check("rd_byte", {24'd0, s}, 32'hA5);
    check("rd_pulses", n, 1);
    // Flag cleared by readback: this one is an address frame again
    frame(1'b1, 10'h2AA, 14, 13, 8'hFF, -1, n, s);
    // Abort a write after 5 payload bits
    frame(1'b0, 10'h155, 7, -1, 8'h00, -1, n, s);
    check("abort_pulses", n, 0);
    check("abort_rx_data", {22'd0, rx_data}, 32'h2AA);
    // Read data with no answer inside the window (late tx_valid ignored) -> timeout
    frame(1'b1, 10'h3C3, 32, 28, 8'hFF, -1, n, s);
    check("timeout_rx_data", {22'd0, rx_data}, 32'h3C3);
    // Two back-to-back address frames: second one goes to read-data
    frame(1'b1, 10'h201, 14, 13, 8'h77, -1, n, s);
    frame(1'b1, 10'h202, 30, 15, 8'h5A, -1, n, s);
    check("b2b_rx_data", {22'd0, rx_data}, 32'h202);
    // Deselect mid-readback keeps the flag so the read can be retried
    frame(1'b1, 10'h210, 14, -1, 8'h00, -1, n, s);
    frame(1'b1, 10'h3FF, 17, 13, 8'hC3, -1, n, s);
    frame(1'b1, 10'h300, 24, 13, 8'h96, -1, n, s);
    check("retry_byte", {24'd0, s}, 32'h96);
    // SS_n rises on the edge that would sample the last payload bit
    frame(1'b0, 10'h0F0, 11, -1, 8'h00, -1, n, s);
    check("lastbit_abort_pulses", n, 0);
    check("lastbit_abort_rx_data", {22'd0, rx_data}, 32'h300);
    // Reset after three readback bits
    frame(1'b1, 10'h220, 14, -1, 8'h00, -1, n, s);
    frame(1'b1, 10'h3AB, 24, 13, 8'hE1, 16, n, s);
    frame(1'b1, 10'h204, 14, 13, 8'hFF, -1, n, s);
    check("post_reset_rx_data", {22'd0, rx_data}, 32'h204);
    check("post_reset_model_flag", {31'd0, m_flag}, 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
